// File: rtl/md_issue_ctrl.sv
// Pipeline-side requester for the multiply/divide unit: issues MD ops, forwards MT writes,
// returns HI/LO for MF reads and stalls the E stage while the unit cannot serve a request.
module md_issue_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        md_start,
    output logic [2:0]  md_mdop,
    output logic [1:0]  md_mtop,
    output logic [31:0] md_a1,
    output logic [31:0] md_a2,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        timeout_err
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMadd  = 4'd5;
    localparam logic [3:0] OpMthi  = 4'd6;
    localparam logic [3:0] OpMtlo  = 4'd7;
    localparam logic [3:0] OpMfhi  = 4'd8;
    localparam logic [3:0] OpMflo  = 4'd9;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic       is_md, is_mt, is_mf;
    logic       free, accept;
    logic [2:0] mdop_enc;

    // Request decode
    always_comb begin
        is_md    = 1'b0;
        is_mt    = 1'b0;
        is_mf    = 1'b0;
        mdop_enc = 3'b000;
        unique case (req_op)
            OpMult:  begin is_md = 1'b1; mdop_enc = 3'b001; end
            OpMultu: begin is_md = 1'b1; mdop_enc = 3'b010; end
            OpDiv:   begin is_md = 1'b1; mdop_enc = 3'b011; end
            OpDivu:  begin is_md = 1'b1; mdop_enc = 3'b100; end
            OpMadd:  begin is_md = 1'b1; mdop_enc = 3'b101; end
            OpMthi, OpMtlo: is_mt = 1'b1;
            OpMfhi, OpMflo: is_mf = 1'b1;
            default: ;
        endcase
    end

    // Unknown and NOP ops never stall, so they are trivially "accepted" and dropped.
    assign free   = (state_q == StIdle) && !md_busy;
    assign stall  = req_valid && (is_md || is_mt || is_mf) && !free;
    assign accept = req_valid && !stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept && is_md) begin
                    op_d    = mdop_enc;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (!md_busy) begin
                    state_d = StIdle;
                end else if (cnt_q == TimeoutCnt) begin
                    // Give up on a hung unit so the pipeline is not frozen forever.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        md_start = 1'b0;
        md_mdop  = 3'b000;
        md_mtop  = 2'b00;
        md_a1    = a_q;
        md_a2    = b_q;
        rd_valid = 1'b0;
        rd_data  = '0;
        if (state_q == StIssue) begin
            md_start = 1'b1;
            md_mdop  = op_q;
        end
        if (accept && is_mt) begin
            md_mtop = (req_op == OpMthi) ? 2'b01 : 2'b10;
            md_a1   = req_a;
        end
        if (accept && is_mf) begin
            rd_valid = 1'b1;
            rd_data  = (req_op == OpMfhi) ? md_hi : md_lo;
        end
    end

    assign timeout_err = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: behavioural MD-unit stub, cycle-level reference model
// of the controller, and literal expectations for the scenario results.
module tb_md_issue_ctrl;

    localparam int TIMEOUT = 16;
    localparam int LAT     = 5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        stall, rd_valid, md_start, md_busy, timeout_err;
    logic [31:0] rd_data, md_a1, md_a2, md_hi, md_lo;
    logic [2:0]  md_mdop;
    logic [1:0]  md_mtop;

    int nchk = 0;
    int nerr = 0;
    int nstart = 0;

    always #5 Clk = ~Clk;

    md_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
        .req_b(req_b), .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
        .md_start(md_start), .md_mdop(md_mdop), .md_mtop(md_mtop), .md_a1(md_a1),
        .md_a2(md_a2), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- MD unit stub ----------------
    logic        stuck;
    int          lat_cnt;
    logic [2:0]  p_op;
    logic [31:0] p_a, p_b;

    function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
        logic signed [63:0] sp;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            3'b001:  return sp;
            3'b010:  return {32'd0, a} * {32'd0, b};
            3'b011:  return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            3'b100:  return {a % b, a / b};
            3'b101:  return hl + sp;
            default: return hl;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            md_busy <= 1'b0;
            md_hi   <= '0;
            md_lo   <= '0;
            lat_cnt <= 0;
        end else if (md_start) begin
            md_busy <= 1'b1;
            lat_cnt <= LAT - 1;
            p_op    <= md_mdop;
            p_a     <= md_a1;
            p_b     <= md_a2;
        end else if (md_mtop == 2'b01) begin
            md_hi <= md_a1;
        end else if (md_mtop == 2'b10) begin
            md_lo <= md_a1;
        end else if (md_busy && !stuck) begin
            if (lat_cnt == 0) begin
                md_busy        <= 1'b0;
                {md_hi, md_lo} <= md_calc(p_op, p_a, p_b, {md_hi, md_lo});
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    always @(negedge Clk) if (!Reset && md_start) nstart <= nstart + 1;

    // ---------------- reference model ----------------
    // m_out: an MD op is in flight; m_age: cycles since it was accepted.
    logic        m_out, m_err;
    int          m_age;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic        e_avail, e_stall, e_acc, e_start, e_mt, e_rdv;
    logic [2:0]  e_mdop;
    logic [1:0]  e_mtop;
    logic [31:0] e_rdd, e_a1;

    function automatic logic [2:0] mdop_of(input logic [3:0] op);
        case (op)
            4'd1: return 3'b001;
            4'd2: return 3'b010;
            4'd3: return 3'b011;
            4'd4: return 3'b100;
            4'd5: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge Clk) begin
        e_avail = !m_out && !md_busy;
        e_stall = req_valid && req_op >= 4'd1 && req_op <= 4'd9 && !e_avail;
        e_acc   = req_valid && !e_stall;
        e_start = m_out && m_age == 0;
        e_mdop  = e_start ? mdop_of(m_op) : 3'b000;
        e_mt    = e_acc && (req_op == 4'd6 || req_op == 4'd7);
        e_mtop  = !e_mt ? 2'b00 : (req_op == 4'd6 ? 2'b01 : 2'b10);
        e_rdv   = e_acc && (req_op == 4'd8 || req_op == 4'd9);
        e_rdd   = !e_rdv ? 32'd0 : (req_op == 4'd8 ? md_hi : md_lo);
        e_a1    = e_mt ? req_a : m_a;
        if (!Reset) begin
            chk("stall", stall, e_stall);
            chk("md_start", md_start, e_start);
            chk("md_mdop", md_mdop, e_mdop);
            chk("md_mtop", md_mtop, e_mtop);
            chk("md_a1", md_a1, e_a1);
            chk("md_a2", md_a2, m_b);
            chk("rd_valid", rd_valid, e_rdv);
            chk("rd_data", rd_data, e_rdd);
            chk("timeout_err", timeout_err, m_err);
        end
        if (Reset) begin
            m_out <= 1'b0;
            m_age <= 0;
            m_a   <= '0;
            m_b   <= '0;
            m_op  <= '0;
            m_err <= 1'b0;
        end else if (m_out) begin
            if (m_age == 0) m_age <= 1;
            else if (!md_busy) m_out <= 1'b0;
            else if (m_age - 1 == TIMEOUT) begin
                m_err <= 1'b1;
                m_out <= 1'b0;
            end else m_age <= m_age + 1;
        end else if (e_acc && req_op >= 4'd1 && req_op <= 4'd5) begin
            m_out <= 1'b1;
            m_age <= 0;
            m_op  <= req_op;
            m_a   <= req_a;
            m_b   <= req_b;
        end
    end

    // ---------------- stimulus ----------------
    // Holds a request until accepted; returns at posedge+1 after the accepting edge.
    task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] data, output logic [1:0] mtop, output logic start,
                       output int stalls, output time t);
        logic done;
        done = 1'b0; stalls = 0; data = '0; mtop = '0; start = 1'b0; t = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge Clk);
            if (!stall) begin
                done = 1'b1; data = rd_data; mtop = md_mtop; start = md_start; t = $time;
            end else begin
                stalls++;
            end
        end
        chk("req_accepted", done, 1'b1);
        @(posedge Clk); #1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  mt;
        logic        st;
        int          ns, n0;
        time         t0, t1;
        logic        seen;

        Reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; stuck = 1'b0;
        idle(2);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_start", md_start, 1'b0);
        chk("rst_mdop", md_mdop, 3'b000);
        chk("rst_mtop", md_mtop, 2'b00);
        chk("rst_rd_data", rd_data, 32'd0);
        idle(1);

        // MULT 7 * -3, then MFLO / MFHI
        n0 = nstart;
        req(4'd1, 32'd7, 32'hFFFF_FFFD, d, mt, st, ns, t0);
        req(4'd9, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("mult_mflo", d, 32'hFFFF_FFEB);
        chk("mult_mf_latency", 32'((t1 - t0) / 10), 32'd8);
        chk("mult_starts", nstart - n0, 32'd1);
        req(4'd8, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("mult_mfhi", d, 32'hFFFF_FFFF);
        chk("mfhi_nostall", ns, 32'd0);

        // DIVU 100 / 7
        req(4'd4, 32'd100, 32'd7, d, mt, st, ns, t0);
        req(4'd8, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("divu_stall_cycles", ns, 32'd7);
        chk("divu_mfhi", d, 32'd2);
        req(4'd9, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("divu_mflo", d, 32'd14);

        // MTHI while idle
        req(4'd6, 32'h1234, 32'd0, d, mt, st, ns, t0);
        chk("mthi_mtop", mt, 2'b01);
        chk("mthi_start", st, 1'b0);
        chk("mthi_nostall", ns, 32'd0);
        req(4'd8, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("mthi_mfhi", d, 32'h1234);

        // MULT 2*3 then MADD 4*5 back to back
        n0 = nstart;
        req(4'd1, 32'd2, 32'd3, d, mt, st, ns, t0);
        req(4'd5, 32'd4, 32'd5, d, mt, st, ns, t1);
        chk("madd_stall_cycles", ns, 32'd7);
        req(4'd9, 32'd0, 32'd0, d, mt, st, ns, t1);
        chk("madd_mflo", d, 32'd26);
        chk("madd_starts", nstart - n0, 32'd2);

        // Reset during the second WAIT cycle
        req(4'd1, 32'd1, 32'd1, d, mt, st, ns, t0);
        idle(2);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0; req_valid = 1'b1; req_op = 4'd9;
        @(negedge Clk);
        chk("rstmid_stall", stall, 1'b0);
        chk("rstmid_start", md_start, 1'b0);
        chk("rstmid_rd_valid", rd_valid, 1'b1);
        idle(1);
        req_valid = 1'b0; req_op = '0;

        // Hung unit: busy never falls
        stuck = 1'b1;
        req(4'd1, 32'd3, 32'd3, d, mt, st, ns, t0);
        seen = 1'b0; t1 = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            if (timeout_err) begin seen = 1'b1; t1 = $time; end
        end
        chk("timeout_seen", seen, 1'b1);
        chk("timeout_cycles", 32'((t1 - t0) / 10), 32'd19);
        idle(1);
        req_valid = 1'b1; req_op = 4'd12;
        @(negedge Clk);
        chk("ignored_op_nostall", stall, 1'b0);
        idle(3);
        req_valid = 1'b0; req_op = '0;
        @(negedge Clk);
        chk("timeout_sticky", timeout_err, 1'b1);
        idle(1);
        stuck = 1'b0; Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        @(negedge Clk);
        chk("timeout_cleared", timeout_err, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
